multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Control unit for the RV32 multicycle core; sits directly upstream of the Datapath and drives every
//  control strobe and mux select from the latched instruction fields and the ALU Zero flag.
//  Moore main FSM plus combinational ALU and immediate decoders. Supports lw, sw, R-type ALU, I-type ALU,
//  beq and jal. Also keeps a retired-instruction counter for bring-up and verification.
// PARAMETERS
//  CNT_W      32   width of instr_retired counter
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  op             in   7   InstrReg[6:0]
//  funct3         in   3   InstrReg[14:12]
//  funct7b5       in   1   InstrReg[30]
//  Zero           in   1   ALU zero flag, combinational from the Datapath
//  PCWrite        out  1   PC register enable
//  AdrSrc         out  1   0 = PC, 1 = Result as memory address
//  MemWrite       out  1   data memory write strobe
//  IRWrite        out  1   instruction/OldPC register enable
//  RegWrite       out  1   register file write enable
//  ResultSrc      out  2   00 = ALUOut, 01 = ReadData, 10 = ALUResult
//  ALUSrcA        out  2   00 = PC, 01 = OldPC, 10 = A
//  ALUSrcB        out  2   00 = WriteData, 01 = ImmExt, 10 = constant 4
//  ImmSrc         out  3   000 = I, 001 = S, 010 = B, 011 = J
//  ALUControl     out  3   000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
//  illegal_op     out  1   high during DECODE when op is unsupported
//  state          out  4   current FSM state, for debug and verification
//  instr_retired  out  CNT_W  count of completed instructions
// BEHAVIOUR
//  State encoding:
//   0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE,
//   6 EXECUTER, 7 ALUWB, 8 EXECUTEI, 9 JAL, 10 BEQ.
//  Reset:
//   - reset high: state = FETCH, instr_retired = 0.
//   - PCWrite, MemWrite, IRWrite and RegWrite are forced 0 while reset is high.
//   - Other outputs show the FETCH decode.
//  Transitions:
//   - FETCH -> DECODE.
//   - DECODE -> MEMADR for lw/sw, EXECUTER for R-type, EXECUTEI for I-type ALU, JAL for jal, BEQ for beq.
//     Any other op -> FETCH with illegal_op = 1.
//   - MEMADR -> MEMREAD for lw, MEMWRITE for sw. MEMREAD -> MEMWB.
//   - EXECUTER and EXECUTEI -> ALUWB. JAL -> ALUWB.
//   - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
//  State outputs (unlisted signals are 0; "x" selects are driven 00):
//   - FETCH:    AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1.
//   - DECODE:   ALUSrcA=01, ALUSrcB=01, ALUOp=add. Branch/jump target goes to ALUOut.
//   - MEMADR:   ALUSrcA=10, ALUSrcB=01, ALUOp=add.
//   - MEMREAD:  ResultSrc=00, AdrSrc=1.
//   - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
//   - MEMWB:    ResultSrc=01, RegWrite=1.
//   - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
//   - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
//   - ALUWB:    ResultSrc=00, RegWrite=1.
//   - JAL:      ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1.
//   - BEQ:      ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1.
//  PCWrite is the only non-Moore output: PCWrite = PCUpdate | (Branch & Zero), combinational.
//  ImmSrc is combinational from op, valid in every state:
//   - lw and I-ALU -> I; sw -> S; beq -> B; jal -> J; others -> 000.
//  ALU decode (ALUOp funct):
//   - funct3 000: sub if (op[5] & funct7b5), else add.
//   - funct3 010: slt. 110: or. 111: and. Others: add.
//  Latency (cycles, including FETCH): lw 5; sw, R, I and jal 4; beq 3; illegal 2.
//  instr_retired:
//   - +1 on the clock edge leaving MEMWB, MEMWRITE, ALUWB or BEQ.
//   - Illegal ops are not counted. Wraps from all-ones to 0.
//  Reset asserted mid-instruction: immediate return to FETCH; no further write strobes that cycle.
// TESTING
//  1. Reset, then release; op = 0110011 (add) -> states 0,1,6,7,0.
//     RegWrite only in ALUWB; instr_retired = 1.
//  2. op = 0000011 (lw) -> states 0,1,2,3,4,0; AdrSrc = 1 in MEMREAD; ResultSrc = 01 and RegWrite = 1 in MEMWB.
//  3. beq with Zero = 1 in BEQ -> PCWrite = 1 that cycle.
//     Repeat with Zero = 0 -> PCWrite = 0; both paths take 3 cycles.
//  4. op = 0010011, funct3 = 000, funct7b5 = 1 -> ALUControl = add (not sub) in EXECUTEI.
//     R-type with the same fields -> sub.
//  5. op = 1111111 -> illegal_op = 1 in DECODE, then FETCH.
//     No MemWrite/RegWrite; instr_retired unchanged.
//  6. Assert reset during MEMWRITE -> MemWrite drops combinationally, state = 0.
//     Preload instr_retired to 0xFFFFFFFF, retire one instruction -> wraps to 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Control unit for the RV32 multicycle core: Moore main FSM, ALU and immediate decoders,
// plus a retired-instruction counter for bring-up.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t  cur;
  alu_op_t alu_op;
  logic    ir_write, reg_write, mem_write, pc_update, branch;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= S_FETCH;
      instr_retired <= '0;
    end else begin
      case (cur)
        S_FETCH:  cur <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_R:         cur <= S_EXECUTER;
            OP_I:         cur <= S_EXECUTEI;
            OP_JAL:       cur <= S_JAL;
            OP_BEQ:       cur <= S_BEQ;
            default:      cur <= S_FETCH;
          endcase
        end
        S_MEMADR:                      cur <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:                     cur <= S_MEMWB;
        S_EXECUTER, S_EXECUTEI, S_JAL: cur <= S_ALUWB;
        default:                       cur <= S_FETCH;
      endcase
      // Only the terminal states of a legal instruction count as a retirement.
      if (cur inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ})
        instr_retired <= instr_retired + CNT_W'(1);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    AdrSrc    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    case (cur)
      S_FETCH:    begin ir_write = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update = 1'b1; end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin AdrSrc = 1'b1; mem_write = 1'b1; end
      S_MEMWB:    begin ResultSrc = 2'b01; reg_write = 1'b1; end
      S_EXECUTER: begin ALUSrcA = 2'b10; alu_op = ALUOP_FUNCT; end
      S_EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      S_BEQ:      begin ALUSrcA = 2'b10; alu_op = ALUOP_SUB; branch = 1'b1; end
      default:    ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_SUB:   ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default:     ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Write strobes are gated by reset directly so they drop the moment reset rises.
  assign PCWrite    = !reset && (pc_update || (branch && Zero));
  assign MemWrite   = !reset && mem_write;
  assign IRWrite    = !reset && ir_write;
  assign RegWrite   = !reset && reg_write;
  assign illegal_op = (cur == S_DECODE) &&
                      !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
  assign state      = cur;

endmodule
